music_box_state_controller: RTL

//  Top-level mode sequencer of the music box: drives currentState to every MusicBoxState_* module and

---
 rtl/music_box_state_controller.sv | 138 +++++++++++++
 1 files changed

// File: rtl/music_box_state_controller.sv
// Music box mode sequencer: button requests -> currentState, held until completion/cancel.
// Optional STATE_TIMEOUT_EN adds a tick_1khz watchdog that forces a return to DoNothing.
module music_box_state_controller #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_MS  = 60000
) (
  input  logic        clock_50Mhz,
  input  logic        reset_n,
  input  logic        tick_1khz,
  input  logic [3:0]  button_pulse,
  input  logic        cancel_pulse,
  input  logic        stateComplete,
  output logic [4:0]  currentState,
  output logic        state_changed,
  output logic        timeout_flag,
  output logic [31:0] debugString
);

  typedef enum logic [4:0] {
    S_IDLE  = 5'd0,
    S_PLAY0 = 5'd1,
    S_PLAY1 = 5'd2,
    S_REC   = 5'd3,
    S_PLAYR = 5'd4
  } state_e;

  state_e state_q, state_d, req;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic sc_s;
  logic armed_q, armed_d;
  logic changed_q, changed_d;
  logic active, entry, done, to_hit, to_exit;
  logic [15:0] timeout_cnt;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], stateComplete};
  assign sc_s   = sync_q[SYNC_STAGES-1];
  assign active = (state_q != S_IDLE);
  assign done   = armed_q && sc_s;

  always_comb begin
    req = S_IDLE;
    priority case (1'b1)
      button_pulse[0]: req = S_PLAY0;
      button_pulse[1]: req = S_PLAY1;
      button_pulse[2]: req = S_REC;
      button_pulse[3]: req = S_PLAYR;
      default:         req = S_IDLE;
    endcase
  end

  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    entry   = 1'b0;
    to_exit = 1'b0;
    if (!active) begin
      if (|button_pulse) begin
        state_d = req;
        armed_d = 1'b0;
        entry   = 1'b1;
      end
    end else begin
      // A stale complete from the previous module must drop before we arm.
      if (!sc_s) armed_d = 1'b1;
      if (cancel_pulse || done) begin
        state_d = S_IDLE;
        armed_d = 1'b0;
      end else if (to_hit) begin
        state_d = S_IDLE;
        armed_d = 1'b0;
        to_exit = 1'b1;
      end
    end
    changed_d = (state_d != state_q);
  end

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      sync_q    <= '0;
      armed_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      armed_q   <= armed_d;
      changed_q <= changed_d;
    end
  end

`ifdef STATE_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic tflag_q, tflag_d;

  assign to_hit = active && ({16'd0, cnt_q} >= 32'(TIMEOUT_MS));

  always_comb begin
    cnt_d   = cnt_q;
    tflag_d = tflag_q;
    if (entry) begin
      cnt_d   = '0;
      tflag_d = 1'b0;
    end else if (active && tick_1khz && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
    if (to_exit) tflag_d = 1'b1;
  end

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      tflag_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      tflag_q <= tflag_d;
    end
  end

  assign timeout_cnt  = cnt_q;
  assign timeout_flag = tflag_q;
`else
  logic        unused_tick;
  logic        unused_flags;
  logic [31:0] unused_lim;

  assign to_hit       = 1'b0;
  assign timeout_cnt  = '0;
  assign timeout_flag = 1'b0;
  assign unused_tick  = tick_1khz;
  assign unused_flags = entry ^ to_exit;
  assign unused_lim   = 32'(TIMEOUT_MS);
`endif

  assign currentState  = state_q;
  assign state_changed = changed_q;
  assign debugString   = {state_q, armed_q, 10'b0, timeout_cnt};

endmodule
